// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: divides the system clock into APU cycles, walks a
// 4-step or 5-step frame, and emits quarter/half-frame pulses plus the frame IRQ.
//
// Handshake note: there is no valid/ready flow here. cfg_we and irq_ack are
// single-cycle strobes sampled on the rising clk edge. qframe_tick and hframe_tick
// are single-cycle registered pulses with no back-pressure, so every consumer must
// sample them on the cycle they are high.
module apu_frame_sequencer #(
  parameter int DIV = 30,
  parameter int Q1  = 3728,
  parameter int Q2  = 7456,
  parameter int Q3  = 11185,
  parameter int Q4  = 14914,
  parameter int Q5  = 18640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       cfg_we,
  input  logic [7:0] cfg_data,
  input  logic       irq_ack,
  output logic       qframe_tick,
  output logic       hframe_tick,
  output logic       frame_irq,
  output logic       mode,
  output logic [2:0] step
);

  // The prescaler needs at least one bit, even when DIV=1 keeps it at zero.
  localparam int             PW          = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  L_PRESC_MAX = PW'(DIV - 1);
  localparam logic [14:0]    L_Q1        = 15'(Q1);
  localparam logic [14:0]    L_Q2        = 15'(Q2);
  localparam logic [14:0]    L_Q3        = 15'(Q3);
  localparam logic [14:0]    L_Q4        = 15'(Q4);
  localparam logic [14:0]    L_Q5        = 15'(Q5);

  // The step index is the visible state. Step 5 of the 5-step frame has no
  // encoding of its own, so the state stays at ST_S4 until the wrap.
  typedef enum logic [2:0] {
    ST_S0 = 3'd0,
    ST_S1 = 3'd1,
    ST_S2 = 3'd2,
    ST_S3 = 3'd3,
    ST_S4 = 3'd4
  } step_t;

  step_t         r_state;
  step_t         w_state_next;

  logic [PW-1:0] r_presc;
  logic [14:0]   r_seq_cnt;
  logic          r_mode;
  logic          r_inhibit;
  logic          r_qframe;
  logic          r_hframe;
  logic          r_irq;

  logic          w_apu_tick;
  logic [14:0]   w_last;
  logic [14:0]   w_cnt_next;
  logic          w_q_pulse;
  logic          w_h_pulse;
  logic          w_irq_set;
  logic          w_unused_cfg;

  // cfg_data[5:0] carries no function in this block.
  assign w_unused_cfg = ^cfg_data[5:0];

  assign w_apu_tick = enable && (r_presc == L_PRESC_MAX);
  assign w_last     = r_mode ? L_Q5 : L_Q4;
  assign w_cnt_next = (r_seq_cnt == w_last) ? 15'd0 : (r_seq_cnt + 15'd1);

  // Decode the pulses for the count the next APU tick lands on.
  always_comb begin
    w_q_pulse = 1'b0;
    w_h_pulse = 1'b0;
    w_irq_set = 1'b0;
    if (w_apu_tick) begin
      if (w_cnt_next == L_Q1 || w_cnt_next == L_Q3) begin
        w_q_pulse = 1'b1;
      end else if (w_cnt_next == L_Q2) begin
        w_q_pulse = 1'b1;
        w_h_pulse = 1'b1;
      end else if (w_cnt_next == L_Q4 && !r_mode) begin
        w_q_pulse = 1'b1;
        w_h_pulse = 1'b1;
        w_irq_set = !r_inhibit;
      end else if (w_cnt_next == L_Q5 && r_mode) begin
        w_q_pulse = 1'b1;
        w_h_pulse = 1'b1;
      end
    end
  end

  // Step next-state: a config write restarts the frame, and each tick that
  // lands on a step count moves to that step.
  always_comb begin
    w_state_next = r_state;
    if (cfg_we) begin
      w_state_next = ST_S0;
    end else if (w_apu_tick) begin
      if (w_cnt_next == 15'd0) begin
        w_state_next = ST_S0;
      end else if (w_cnt_next == L_Q1) begin
        w_state_next = ST_S1;
      end else if (w_cnt_next == L_Q2) begin
        w_state_next = ST_S2;
      end else if (w_cnt_next == L_Q3) begin
        w_state_next = ST_S3;
      end else if (w_cnt_next == L_Q4) begin
        w_state_next = ST_S4;
      end
    end
  end

  // Step state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_S0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Prescaler, step counter, config, pulses and IRQ. A config write takes
  // priority over a coincident APU tick and discards that tick entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc   <= '0;
      r_seq_cnt <= '0;
      r_mode    <= 1'b0;
      r_inhibit <= 1'b0;
      r_qframe  <= 1'b0;
      r_hframe  <= 1'b0;
      r_irq     <= 1'b0;
    end else if (cfg_we) begin
      r_mode    <= cfg_data[7];
      r_inhibit <= cfg_data[6];
      r_presc   <= '0;
      r_seq_cnt <= '0;
      // Entering 5-step mode clocks the quarter- and half-frame units immediately.
      r_qframe  <= cfg_data[7];
      r_hframe  <= cfg_data[7];
      if (cfg_data[6] || irq_ack) begin
        r_irq <= 1'b0;
      end
    end else begin
      r_qframe <= w_q_pulse;
      r_hframe <= w_h_pulse;
      if (enable) begin
        r_presc <= (r_presc == L_PRESC_MAX) ? '0 : PW'(r_presc + 1'b1);
      end
      if (w_apu_tick) begin
        r_seq_cnt <= w_cnt_next;
      end
      // Setting the IRQ beats a coincident acknowledge.
      if (w_irq_set) begin
        r_irq <= 1'b1;
      end else if (irq_ack) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign qframe_tick = r_qframe;
  assign hframe_tick = r_hframe;
  assign frame_irq   = r_irq;
  assign mode        = r_mode;
  assign step        = r_state;

endmodule

// File: doc/apu_frame_sequencer.md
Name: apu_frame_sequencer

Overview:
Frame sequencer for the APU, the timing master for the square-wave channels. It divides the system clock into APU cycles and emits quarter-frame pulses (envelope, linear clocks) and half-frame pulses (length counter, sweep clocks) in 4-step or 5-step mode. It also raises the frame IRQ. Software configures it through a single mode/IRQ byte. All channel instances receive its pulses in parallel.

Parameters:
DIV, 30, system clocks per APU cycle (>=1)
Q1, 3728, APU-cycle count of step 1
Q2, 7456, APU-cycle count of step 2
Q3, 11185, APU-cycle count of step 3
Q4, 14914, APU-cycle count of step 4; last count in 4-step mode
Q5, 18640, APU-cycle count of step 5; last count in 5-step mode (Q1<Q2<Q3<Q4<Q5<2^15)

Ports:
clk          input   1   system clock
rst          input   1   synchronous reset, active high
enable       input   1   1 = sequencer runs; 0 = prescaler and step counter hold
cfg_we       input   1   one-cycle write strobe for cfg_data
cfg_data     input   8   [7] mode (0 = 4-step, 1 = 5-step); [6] IRQ inhibit; [5:0] ignored
irq_ack      input   1   one-cycle frame-IRQ clear (status read)
qframe_tick  output  1   one-clock quarter-frame pulse
hframe_tick  output  1   one-clock half-frame pulse
frame_irq    output  1   frame interrupt level
mode         output  1   current mode bit
step         output  3   current step index 0..4 (debug/status)

Behaviour:
- Clock/reset: one clock, clk; rst is synchronous and active high. All state is updated only on the clk rising edge.
- Reset values: qframe_tick=0, hframe_tick=0, frame_irq=0, mode=0, inhibit=0, step=0, prescaler=0, seq_cnt=0.
- Prescaler:
  - Counts 0..DIV-1 while enable=1.
  - apu_tick = enable && prescaler==DIV-1; the prescaler wraps to 0 on the same edge.
  - DIV=1 makes apu_tick = enable.
- Step counter:
  - seq_cnt is 15 bits and advances only on apu_tick.
  - LAST = Q4 in 4-step mode, Q5 in 5-step mode.
  - On apu_tick: seq_cnt <= (seq_cnt==LAST) ? 0 : seq_cnt+1.
  - Period is therefore LAST+1 APU cycles.
- Pulses are registered. They assert for exactly one clk on the edge where apu_tick moves seq_cnt to the step value:
  - seq_cnt→Q1: qframe only.
  - seq_cnt→Q2: qframe and hframe.
  - seq_cnt→Q3: qframe only.
  - seq_cnt→Q4, mode 0: qframe and hframe; frame_irq<=1 if inhibit=0.
  - seq_cnt→Q4, mode 1: no pulse.
  - seq_cnt→Q5, mode 1: qframe and hframe.
  - seq_cnt→0 (wrap): no pulse.
- step output:
  - 0 after reset or write.
  - 1, 2, 3, 4 after reaching Q1, Q2, Q3, Q4 respectively.
  - Mode 1 only: 5 is not encoded; step stays 4 until the wrap.
  - Returns to 0 on wrap.
- Config write (cfg_we=1):
  - Latch mode<=cfg_data[7] and inhibit<=cfg_data[6].
  - Clear seq_cnt and prescaler to 0; step<=0.
  - If cfg_data[7]=1: qframe_tick and hframe_tick both pulse on this edge (visible the next cycle).
  - If cfg_data[6]=1: frame_irq<=0.
  - The write is accepted regardless of enable; the immediate 5-step pulse still fires with enable=0.
- Simultaneous events:
  - cfg_we with apu_tick: the write wins; the tick's step pulse and advance are discarded.
  - irq_ack with the Q4 IRQ set: set wins, frame_irq stays 1.
  - irq_ack alone: frame_irq<=0 on the next edge.
  - cfg_we (inhibit=1) with an IRQ set: clear wins.
- Pulses never exceed one clk; at most one qframe and one hframe per edge.
- enable=0 mid-frame freezes prescaler and seq_cnt; resuming continues with no lost or duplicate pulses.
- rst mid-frame: all state returns to reset values on that edge; a pulse asserted in the same cycle drops the next cycle.

Test Plan:
Shared bench parameters: DIV=2, Q1=3, Q2=7, Q3=11, Q4=15, Q5=19.
1. Reset, enable=1, mode 0 → pulses at seq_cnt 3,7,11,15. hframe at 7 and 15 only. Period 32 clks. frame_irq rises at the clk where seq_cnt=15 and stays high.
2. Scenario 1, then irq_ack for 1 clk → frame_irq=0 next clk; re-asserts at the next Q4.
3. Write cfg_data=0x80 mid-frame → qframe=hframe=1 the next clk; seq_cnt=0. Next pulses at 3,7,11,19 (hframe at 7,19); nothing at 15; no IRQ ever; period 40 clks.
4. Write 0x40, run 3 frames → no IRQ. A pre-set frame_irq clears on the write edge.
5. Hold enable=0 for 50 clks at seq_cnt=5 → no pulses and counters frozen; resume → Q2 pulse occurs 2 APU cycles (4 clks) later.
6. Corner cases:
   - cfg_we on an apu_tick reaching Q1 → no Q1 pulse; seq_cnt=0.
   - irq_ack coincident with the Q4 edge → frame_irq stays 1.
   - rst asserted at seq_cnt=9 → all outputs 0 the next clk.
